// File: rtl/spi_fsm.sv
// spi_fsm: transaction controller for the SPI memory slave.
// Runs an address/R-W phase, then a read or write data phase, and drives every enable in the datapath.
module spi_fsm #(
   parameter int unsigned ADDR_BITS = 7,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned CNTW      = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic cs_cond,
   input  logic sclk_pos,
   input  logic sclk_neg,
   input  logic rw_bit,
   output logic addr_we,
   output logic sr_we,
   output logic dm_we,
   output logic miso_bufe,
   output logic busy
);

   typedef enum logic [3:0] {
      IDLE,
      GET_ADDR,
      GOT_ADDR,
      READ_WAIT,
      READ_LOAD,
      READ_SHIFT,
      WRITE_GET,
      WRITE_STORE,
      DONE
   } state_e;

   // Phase-completing edge is recognised by the count it arrives on, so the counter never
   // has to hold the terminal value itself.
   localparam logic [CNTW-1:0] ADDR_LAST = CNTW'(ADDR_BITS);
   localparam logic [CNTW-1:0] DATA_LAST = CNTW'(DATA_BITS - 1);

   state_e            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
         if (!cs_cond) begin
            state_d = GET_ADDR;
         end
      end else if (cs_cond) begin
         // Abort wins over any edge pulse arriving in the same cycle.
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            GET_ADDR: begin
               if (sclk_pos) begin
                  if (cnt_q == ADDR_LAST) begin
                     state_d = GOT_ADDR;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNTW'(1);
                  end
               end
            end
            GOT_ADDR: begin
               state_d = rw_bit ? READ_WAIT : WRITE_GET;
            end
            READ_WAIT: begin
               state_d = READ_LOAD;
            end
            READ_LOAD: begin
               state_d = READ_SHIFT;
            end
            READ_SHIFT: begin
               if (sclk_neg) begin
                  if (cnt_q == DATA_LAST) begin
                     state_d = DONE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNTW'(1);
                  end
               end
            end
            WRITE_GET: begin
               if (sclk_pos) begin
                  if (cnt_q == DATA_LAST) begin
                     state_d = WRITE_STORE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + CNTW'(1);
                  end
               end
            end
            WRITE_STORE: begin
               state_d = DONE;
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      addr_we   = 1'b0;
      sr_we     = 1'b0;
      dm_we     = 1'b0;
      miso_bufe = 1'b0;
      busy      = (state_q != IDLE);
      unique case (state_q)
         GOT_ADDR:    addr_we   = 1'b1;
         READ_LOAD:   sr_we     = 1'b1;
         READ_SHIFT:  miso_bufe = 1'b1;
         WRITE_STORE: dm_we     = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/spi_fsm.md
# spi_fsm

Transaction controller for the SPI memory slave. It consumes the one-cycle edge pulses and conditioned levels produced by the input conditioners on CS and SCLK. It then sequences the shift register, address latch, data memory and MISO tri-state buffer through an address/R-W phase followed by a read or write data phase. It is the only block that drives write enables and output enables in the SPI datapath.

## Interface
- ADDR_BITS, 7, address bits per transaction; the R/W bit follows them, so the address phase is ADDR_BITS+1 SCLK rising edges
- DATA_BITS, 8, data bits per transaction
- CNTW, 4, edge counter width; requires ADDR_BITS+1 ≤ 2^CNTW−1 and DATA_BITS ≤ 2^CNTW−1
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- cs_cond  in  1  conditioned chip select, active low
- sclk_pos  in  1  one-cycle pulse from the SCLK conditioner on a rising edge
- sclk_neg  in  1  one-cycle pulse from the SCLK conditioner on a falling edge
- rw_bit  in  1  bit 0 of the shift register parallel output (1 = read, 0 = write)
- addr_we  out  1  address latch enable
- sr_we  out  1  shift register parallel-load enable
- dm_we  out  1  data memory write enable
- miso_bufe  out  1  MISO tri-state buffer enable
- busy  out  1  high whenever state ≠ IDLE

## Operation
- All outputs are Moore outputs, decoded from the registered state only.
- Reset: state IDLE, counter 0, all outputs 0 from the first clock after reset is sampled high. Reset overrides every other input, including mid-transaction.
- IDLE: no outputs asserted; counter held at 0. If cs_cond = 0, the next state is GET_ADDR.
- GET_ADDR: each sclk_pos increments the counter. On the pulse that brings the count to ADDR_BITS+1, the next state is GOT_ADDR and the counter clears.
- GOT_ADDR (1 cycle): addr_we = 1. rw_bit is sampled here. rw_bit = 1 selects READ_WAIT; otherwise the next state is WRITE_GET.
- READ_WAIT (1 cycle): no outputs asserted; covers the 1-cycle memory read latency.
- READ_LOAD (1 cycle): sr_we = 1.
- READ_SHIFT: miso_bufe = 1. Each sclk_neg increments the counter. On the DATA_BITS-th pulse, the next state is DONE and the counter clears.
- WRITE_GET: each sclk_pos increments the counter. On the DATA_BITS-th pulse, the next state is WRITE_STORE and the counter clears.
- WRITE_STORE (1 cycle): dm_we = 1. Next state is DONE.
- DONE: no outputs asserted except busy. If cs_cond = 1, the next state is IDLE.
- Edge pulses are ignored in every state that does not count that edge. sclk_neg is ignored in GET_ADDR and WRITE_GET; sclk_pos is ignored in READ_SHIFT; both are ignored in the fixed one-cycle states and in DONE and IDLE.
- Abort: cs_cond = 1 in any state other than IDLE forces the next state to IDLE and the counter to 0.
  - Abort has priority over an edge pulse in the same cycle.
  - A fixed one-cycle state already entered still asserts its output for that cycle.
  - A write aborted before WRITE_STORE never asserts dm_we.
- The counter never wraps: it is cleared on every phase-completing transition and on abort.

## Timing
- Edge pulse sampled high at clock edge N.
  - If it completes the address phase, GOT_ADDR is the state from N+1, and addr_we is high for that cycle only.
  - Read path: READ_WAIT at N+2, READ_LOAD (sr_we) at N+3, miso_bufe high from N+4.
  - Write path: WRITE_GET from N+2.
- miso_bufe drops in the cycle after the DATA_BITS-th sclk_neg is sampled.
- dm_we is high for exactly the one cycle after the DATA_BITS-th write-phase sclk_pos is sampled.
- cs_cond low sampled at edge M in IDLE gives busy = 1 from M+1. An sclk_pos sampled at M itself is not counted.
- Each of addr_we, sr_we and dm_we is high at most once per transaction, for exactly one cycle.

## Test plan
- Reset: assert reset for 2 cycles after 4 address pulses. Outputs and busy are 0, and the next transaction still needs 8 pulses before addr_we.
- Write: cs low, 8 sclk_pos with rw_bit = 0, then 8 sclk_pos.
  - addr_we is high 1 cycle after the 8th address pulse.
  - dm_we is high 1 cycle after the 8th data pulse.
  - busy stays 1 until cs_cond = 1, then returns to 0 the next cycle.
- Read: cs low, 8 sclk_pos with rw_bit = 1.
  - sr_we is high exactly at N+3.
  - miso_bufe is high from N+4 through the cycle of the 8th sclk_neg, and 0 the cycle after.
- Abort: cs_cond = 1 after 5 write data pulses. State returns to IDLE the next cycle and dm_we is never asserted.
  - A second abort, with cs_cond = 1 in the same cycle as the 8th address pulse, gives no addr_we.
- Ignored edges:
  - sclk_pos pulses in IDLE and DONE, and sclk_neg pulses in GET_ADDR, leave the count unchanged.
  - 7 sclk_pos followed by cs_cond = 1 gives no addr_we.
- Back-to-back: a write then a read with cs high for a single cycle between them. Both complete, with one addr_we each.
